axi_cmd_arbiter: RTL and testbench
==================================

# axi_cmd_arbiter

Round-robin command arbiter that shares one `axi4_master` control interface between `NUM_REQ` requesters. It accepts one burst command at a time from a selected requester, latches its address, length, direction and write payload, and sequences the master through a start pulse and its `done` handshake. It returns read data and a completion pulse tagged with the owner's index. It sits directly in front of `axi4_master`, on the same clock.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `BURST_LEN`, 16, maximum beats per burst; payload array depth
- `ACLK`  in  1  single clock, rising edge
- `ARESETN`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester command request
- `req_write`  in  NUM_REQ  1 = write burst, 0 = read burst
- `req_addr`  in  NUM_REQ x ADDR_WIDTH  burst start address
- `req_len`  in  NUM_REQ x 8  AXI LEN encoding (beats-1)
- `req_wdata`  in  NUM_REQ x BURST_LEN x DATA_WIDTH  write payload
- `req_ready`  out  NUM_REQ  one-hot accept strobe
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_id`  out  $clog2(NUM_REQ)  owner of the completed or rejected command
- `rsp_err`  out  1  qualifies `rsp_valid`; 1 = command rejected (length illegal)
- `rsp_rdata`  out  BURST_LEN x DATA_WIDTH  read payload, valid with `rsp_valid` on reads
- `start_write`, `start_read`  out  1  one-cycle start pulses to the master
- `target_addr`  out  ADDR_WIDTH  to master
- `burst_len`  out  8  to master
- `write_data`  out  BURST_LEN x DATA_WIDTH  to master
- `read_data`  in  BURST_LEN x DATA_WIDTH  from master
- `done`  in  1  master completion pulse
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - Combinational round-robin pick among `req_valid`, starting at `rr_ptr`.
  - If any request is valid: assert `req_ready[g]` in that same cycle.
  - Latch `req_write[g]`, `req_addr[g]`, `req_len[g]`, `req_wdata[g]` and `g` into the command register.
  - Set `rr_ptr <= g+1` (mod NUM_REQ).
- Length check:
  - If `req_len[g] > BURST_LEN-1`, the command is accepted but never issued: go directly to RESP with `rsp_err=1`.
  - Otherwise go to ISSUE.
- ISSUE: assert `start_write` or `start_read` for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - Hold `target_addr`, `burst_len` and `write_data` stable from the register.
  - On `done`, capture `read_data` into the `rsp_rdata` register (reads only) and go to RESP.
- RESP: `rsp_valid=1` for one cycle with `rsp_id` and `rsp_err`, then return to IDLE.
- Arbitration:
  - Requests are sampled only in IDLE; `req_valid` in other states is ignored.
  - A requester holds `req_valid` until it sees `req_ready`.
  - A requester may reassert `req_valid` in the cycle after `rsp_valid`. Fairness guarantees it is not regranted ahead of other pending requesters.
- `rsp_rdata` holds the last read payload until the next read completes. Writes leave it unchanged.

## Timing
- Reset (asynchronous): state=IDLE, `rr_ptr`=0. The following outputs and registers are 0: `req_ready`, `rsp_valid`, `rsp_err`, `rsp_id`, `rsp_rdata`, `start_write`, `start_read`, `target_addr`, `burst_len`, `write_data`, `busy`.
- Accept at cycle T (IDLE, `req_ready` high):
  - Start pulse at T+1.
  - If `done` arrives at cycle D, `rsp_valid` occurs at D+1.
  - Earliest next accept is D+2.
- Rejected length: accept at T, `rsp_valid`/`rsp_err` at T+1; no start pulse.
- `done` seen in any state other than WAIT_DONE is ignored.
- `done` in the same cycle as the start pulse is ignored; the earliest legal `done` is T+2.
- Reset asserted mid-burst:
  - The FSM aborts to IDLE and no `rsp_valid` is issued.
  - The master shares the same reset and is reset with it.
- Maximum one outstanding command; no pipelining.

## Structure
- Package `axi_m2s_pkg`: FSM state enum `arb_state_e`, AXI LEN/SIZE/BURST constants, `ID_W` helper function.
- Sub-module `rr_arbiter`:
  - Parameterised NUM_REQ; inputs `req`, `ptr`; outputs one-hot `gnt` and index.
  - Purely combinational.
  - Reused by later multi-master blocks.

## Test plan
- Single read: req 2 valid, `req_len`=3, addr 0x1000. Expect:
  - `req_ready[2]` at T and `start_read` at T+1 with `target_addr`=0x1000, `burst_len`=3.
  - With `done` at T+5: `rsp_valid` at T+6, `rsp_id`=2, `rsp_err`=0, and `rsp_rdata` equal to the driven `read_data`.
- Fairness: all 4 requesters held valid continuously. Expect grant order 0,1,2,3,0 and no requester granted twice before another is served.
- Illegal length: `req_len`=16 with BURST_LEN=16. Expect `rsp_valid` and `rsp_err`=1 one cycle after accept, with `start_*` never asserted.
- Write payload stability: req 1 write with data 0xA0..0xAF. Expect `write_data` constant from T+1 until `done`, even when `req_wdata[1]` changes after accept.
- Spurious `done`: pulse `done` in IDLE and in ISSUE. Expect no `rsp_valid`, and correct completion on the later real `done`.
- Reset during WAIT_DONE: deassert `ARESETN` asynchronously. Expect all outputs at 0 immediately and `rr_ptr`=0; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/axi_m2s_pkg.sv
// rtl/axi_m2s_pkg.sv - shared types and AXI encodings for the command arbiter
package axi_m2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    localparam int         AXI_LEN_W       = 8;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
    import axi_m2s_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [2*NUM_REQ-1:0] rotated;

    // Rotating a doubled copy right by ptr puts the highest-priority requester at bit 0.
    always_comb begin
        int sum;
        sum     = 0;
        rotated = {req, req} >> ptr;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && rotated[k]) begin
                gnt_any = 1'b1;
                sum     = int'(ptr) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                gnt_idx = IDX_W'(sum);
            end
        end
    end

    assign gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/axi_cmd_arbiter.sv
// rtl/axi_cmd_arbiter.sv - round-robin burst command arbiter in front of axi4_master
module axi_cmd_arbiter
    import axi_m2s_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    localparam int IDX_W     = id_w(NUM_REQ),
    localparam int PAY_W     = BURST_LEN * DATA_WIDTH
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*PAY_W-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    output logic [IDX_W-1:0]                rsp_id,
    output logic                            rsp_err,
    output logic [PAY_W-1:0]                rsp_rdata,
    output logic                            start_write,
    output logic                            start_read,
    output logic [ADDR_WIDTH-1:0]           target_addr,
    output logic [AXI_LEN_W-1:0]            burst_len,
    output logic [PAY_W-1:0]                write_data,
    input  logic [PAY_W-1:0]                read_data,
    input  logic                            done,
    output logic                            busy
);

    arb_state_e state, state_nxt;

    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic                  accept;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [AXI_LEN_W-1:0]  sel_len;
    logic [PAY_W-1:0]      sel_wdata;
    logic                  len_bad;

    logic                  cmd_write;
    logic                  cmd_err;
    logic [IDX_W-1:0]      cmd_id;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign accept = (state == ST_IDLE) && gnt_any;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                sel_write = req_write[k];
                sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = req_len[k*AXI_LEN_W +: AXI_LEN_W];
                sel_wdata = req_wdata[k*PAY_W +: PAY_W];
            end
        end
    end

    // Over-long bursts are accepted so the requester is released, then answered with an error.
    assign len_bad = (sel_len > AXI_LEN_W'(BURST_LEN - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_nxt = len_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // req_ready is combinational, so it is masked while reset is held.
    always_comb begin
        req_ready   = '0;
        start_write = 1'b0;
        start_read  = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (ARESETN) begin
                    req_ready = gnt;
                end
            end
            ST_ISSUE: begin
                start_write = cmd_write;
                start_read  = !cmd_write;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = cmd_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rr_ptr      <= '0;
            cmd_write   <= 1'b0;
            cmd_err     <= 1'b0;
            cmd_id      <= '0;
            target_addr <= '0;
            burst_len   <= '0;
            write_data  <= '0;
            rsp_rdata   <= '0;
        end else begin
            if (accept) begin
                cmd_write   <= sel_write;
                cmd_err     <= len_bad;
                cmd_id      <= gnt_idx;
                target_addr <= sel_addr;
                burst_len   <= sel_len;
                write_data  <= sel_wdata;
                rr_ptr      <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if ((state == ST_WAIT_DONE) && done && !cmd_write) begin
                rsp_rdata <= read_data;
            end
        end
    end

    assign rsp_id = cmd_id;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// tb/tb_axi_cmd_arbiter.sv - directed self-checking bench for axi_cmd_arbiter
module tb_axi_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 16;
    localparam int PW = BL * DW;
    localparam int IW = 2;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*8-1:0]    req_len;
    logic [N*PW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic [PW-1:0]     rsp_rdata;
    logic              start_write;
    logic              start_read;
    logic [AW-1:0]     target_addr;
    logic [7:0]        burst_len;
    logic [PW-1:0]     write_data;
    logic [PW-1:0]     read_data;
    logic              done;
    logic              busy;

    int n_pass = 0;
    int n_chk  = 0;

    logic [PW-1:0] rd_pat_a;
    logic [PW-1:0] rd_pat_c;
    logic [PW-1:0] rd_junk;
    logic [PW-1:0] wr_pat;

    always #5 ACLK = ~ACLK;

    axi_cmd_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .start_write (start_write),
        .start_read  (start_read),
        .target_addr (target_addr),
        .burst_len   (burst_len),
        .write_data  (write_data),
        .read_data   (read_data),
        .done        (done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic mid();
        @(negedge ACLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [7:0] l);
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_len[i*8 +: 8]     = l;
    endtask

    function automatic logic [PW-1:0] pat(input logic [DW-1:0] base);
        logic [PW-1:0] p;
        for (int b = 0; b < BL; b++) begin
            p[b*DW +: DW] = base + DW'(b);
        end
        return p;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_pat_a  = pat(32'hD000_0000);
        rd_pat_c  = pat(32'hC000_0000);
        rd_junk   = pat(32'hEEEE_0000);
        wr_pat    = pat(32'h0000_00A0);
        ARESETN   = 1'b0;
        req_valid = '1;
        req_write = '0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        read_data = '0;
        done      = 1'b0;

        // Reset state, with every requester already asking.
        mid();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_start", {start_write, start_read}, 0);
        chk("rst_target_addr", target_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        cyc();
        ARESETN = 1'b1;
        mid();

        // Fairness: all four held valid, zero-length reads answered quickly.
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("fair_grant%0d", r), req_ready, N'(1) << (r % N));
            cyc();
            mid();
            chk($sformatf("fair_start%0d", r), start_read, 1);
            chk($sformatf("fair_ignore%0d", r), req_ready, 0);
            cyc();
            done = 1'b1;
            mid();
            chk($sformatf("fair_noresp%0d", r), rsp_valid, 0);
            cyc();
            done = 1'b0;
            if (r == 4) req_valid = '0;
            mid();
            chk($sformatf("fair_rsp%0d", r), rsp_valid, 1);
            chk($sformatf("fair_id%0d", r), rsp_id, r % N);
            cyc();
            mid();
        end
        chk("fair_idle_ready", req_ready, 0);
        chk("fair_idle_busy", busy, 0);

        // Single read from requester 2.
        cyc();
        set_req(2, 1'b0, 32'h1000, 8'd3);
        mid();
        chk("rd_ready", req_ready, 4'b0100);
        cyc();
        req_valid[2] = 1'b0;
        mid();
        chk("rd_start", {start_write, start_read}, 2'b01);
        chk("rd_addr", target_addr, 32'h1000);
        chk("rd_len", burst_len, 3);
        chk("rd_busy", busy, 1);
        cyc();
        mid();
        chk("rd_start_once", start_read, 0);
        chk("rd_wait", rsp_valid, 0);
        cyc();
        cyc();
        cyc();
        done      = 1'b1;
        read_data = rd_pat_a;
        mid();
        chk("rd_at_done", rsp_valid, 0);
        cyc();
        done      = 1'b0;
        read_data = '0;
        mid();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_id", rsp_id, 2);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_rdata", rsp_rdata, rd_pat_a);
        cyc();
        mid();
        chk("rd_after", {rsp_valid, busy}, 0);

        // Illegal length on requester 0: error response, no start pulse.
        cyc();
        set_req(0, 1'b1, 32'h4000, 8'd16);
        mid();
        chk("bad_ready", req_ready, 4'b0001);
        cyc();
        req_valid[0] = 1'b0;
        mid();
        chk("bad_rsp_valid", rsp_valid, 1);
        chk("bad_rsp_err", rsp_err, 1);
        chk("bad_rsp_id", rsp_id, 0);
        chk("bad_no_start", {start_write, start_read}, 0);
        cyc();
        mid();
        chk("bad_after", {rsp_valid, busy, start_write, start_read}, 0);

        // Write from requester 1 at the maximum legal length; payload must stay latched.
        cyc();
        set_req(1, 1'b1, 32'h2000, 8'd15);
        req_wdata[PW +: PW] = wr_pat;
        mid();
        chk("wr_ready", req_ready, 4'b0010);
        cyc();
        req_valid[1]        = 1'b0;
        req_wdata[PW +: PW] = ~wr_pat;
        mid();
        chk("wr_start", {start_write, start_read}, 2'b10);
        chk("wr_len", burst_len, 15);
        chk("wr_data_t1", write_data, wr_pat);
        cyc();
        mid();
        chk("wr_data_t2", write_data, wr_pat);
        cyc();
        done = 1'b1;
        mid();
        chk("wr_data_done", write_data, wr_pat);
        cyc();
        done = 1'b0;
        mid();
        chk("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("wr_rsp_id", rsp_id, 1);
        chk("wr_rdata_kept", rsp_rdata, rd_pat_a);

        // Spurious done in IDLE and ISSUE.
        cyc();
        done      = 1'b1;
        read_data = rd_junk;
        mid();
        cyc();
        done = 1'b0;
        mid();
        chk("sp_idle_norsp", {rsp_valid, busy}, 0);
        cyc();
        set_req(3, 1'b0, 32'h3000, 8'd1);
        done = 1'b1;
        mid();
        chk("sp_ready", req_ready, 4'b1000);
        cyc();
        req_valid[3] = 1'b0;
        mid();
        chk("sp_start", start_read, 1);
        cyc();
        done = 1'b0;
        mid();
        chk("sp_issue_norsp", rsp_valid, 0);
        chk("sp_busy", busy, 1);
        cyc();
        done      = 1'b1;
        read_data = rd_pat_c;
        mid();
        cyc();
        done      = 1'b0;
        read_data = '0;
        mid();
        chk("sp_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("sp_rsp_id", rsp_id, 3);
        chk("sp_rdata", rsp_rdata, rd_pat_c);

        // Reset while waiting on a write from requester 2 (moves rr_ptr to 3 first).
        cyc();
        set_req(2, 1'b1, 32'h5000, 8'd2);
        req_wdata[2*PW +: PW] = wr_pat;
        mid();
        chk("rst2_ready", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b1010;
        mid();
        chk("rst2_start", start_write, 1);
        cyc();
        mid();
        chk("rst2_wait_ignore", req_ready, 0);
        chk("rst2_wait_busy", busy, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_regs", {target_addr, burst_len, rsp_id}, 0);
        chk("rst2_write_data", write_data, 0);
        chk("rst2_rsp_rdata", rsp_rdata, 0);
        chk("rst2_ready_masked", req_ready, 0);
        cyc();
        done = 1'b1;
        mid();
        chk("rst2_no_rsp", rsp_valid, 0);
        cyc();
        done    = 1'b0;
        ARESETN = 1'b1;
        mid();
        chk("rst2_first_grant", req_ready, 4'b0010);
        cyc();
        req_valid = '0;
        mid();
        chk("rst2_busy_after", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
